uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Configuration and buffering controller for the UART receiver. It owns the receiver's frame-format inputs (`par`, `d_num`, `s_num`) and changes them only between frames. It captures each completed frame (data plus parity/frame error flags) into a small FIFO and flags overrun when the host does not drain it in time. It sits between the `receiver` instance and the host-side register interface, on the receiver's 16x oversampling clock.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `DW`, 8: data width. Fixed 8 for the current receiver.

Ports:
- `clk_rx`  in  1  16x oversampling clock; the single clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_wr`  in  1  one-cycle request to load a new frame format.
- `cfg_par`  in  2  requested parity: 0/3 = none, 1 = odd, 2 = even.
- `cfg_d_num`  in  1  requested data bits: 0 = 7, 1 = 8.
- `cfg_s_num`  in  1  requested stop bits: 0 = 1, 1 = 2.
- `par`  out  2  applied parity, to receiver.
- `d_num`  out  1  applied data bits, to receiver.
- `s_num`  out  1  applied stop bits, to receiver.
- `cfg_pending`  out  1  a format change is accepted but not yet applied.
- `rx_busy`  in  1  receiver is inside a frame (start detected, stop not finished).
- `rx_done`  in  1  one-cycle pulse when the receiver finishes a stop bit.
- `rx_dout`  in  DW  receiver data, valid with `rx_done`.
- `rx_err`  in  3  receiver `{parity, frame, overrun}`, valid with `rx_done`.
- `rd_en`  in  1  host pop of the FIFO head.
- `rd_data`  out  DW  FIFO head (first-word-fall-through).
- `rd_err`  out  2  head entry `{parity, frame}`.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `overrun`  out  1  sticky: a frame was dropped because the FIFO was full.
- `ovr_clr`  in  1  clears `overrun`.

## Operation

- Reset (sampled at a `clk_rx` edge with `reset`=1):
  - Format returns to the 8N1 default: `par`=0, `d_num`=1, `s_num`=0.
  - `cfg_pending`=0; the shadow config is discarded.
  - FIFO flushed: `empty`=1, `full`=0, `rd_data`=0, `rd_err`=0.
  - `overrun`=0.
  - Reset mid-frame or mid-config has the same effect.
- Config FSM states:
  - RUN: on `cfg_wr`, latch the shadow from `cfg_*`. Go to APPLY if `rx_busy`=0, otherwise to WAIT_IDLE.
  - WAIT_IDLE: on `cfg_wr`, overwrite the shadow (last write wins). When `rx_busy`=0, go to APPLY.
  - APPLY: load `par`/`d_num`/`s_num` from the shadow, then return to RUN. A `cfg_wr` in this cycle re-latches the shadow and goes to WAIT_IDLE or APPLY by the same rule as RUN.
  - `cfg_pending`=1 in WAIT_IDLE and APPLY.
- FIFO write:
  - On `rx_done`, store `{rx_err[2:1], rx_dout}`.
  - When the applied `d_num`=0, bit 7 is stored as 0.
  - `rx_err[0]` (receiver overrun) is ignored; overrun is owned here.
  - Frames completing in WAIT_IDLE are stored normally.
- FIFO read:
  - `rd_data`/`rd_err` show the head whenever `empty`=0, and are 0 when empty.
  - `rd_en` pops the head; `rd_en` while empty is ignored.
- Pointers and count:
  - Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
  - Occupancy count is log2(`DEPTH`)+1 bits.
  - `full` = (count == `DEPTH`); `empty` = (count == 0).
- Overrun and simultaneous events:
  - `rx_done` while `full`=1 and no `rd_en`: the frame is dropped and `overrun` is set.
  - `rx_done` and `rd_en` in the same cycle while full: pop and push both occur, count stays `DEPTH`, no overrun.
  - `rx_done` and `rd_en` in the same cycle while empty: push only; the new entry appears next cycle.
  - `ovr_clr` in the same cycle as a new overrun: set wins.

## Timing

- `rx_done` sampled at edge N: `empty` deasserts and `rd_data` is valid after edge N (visible in cycle N+1).
- `rd_en` sampled at edge N: the next head (or `empty`=1) is visible after edge N.
- `cfg_wr` at edge N with `rx_busy`=0:
  - `cfg_pending`=1 after edge N.
  - New `par`/`d_num`/`s_num` and `cfg_pending`=0 after edge N+1.
  - Config latency is 2 edges.
- `cfg_wr` with `rx_busy`=1: outputs hold the old format until the first edge M with `rx_busy`=0. The new format is visible after edge M+1.
- All outputs are registered, except `rd_data`/`rd_err`, which are mux outputs of registered storage gated by `empty`.

## Test plan

- Reset, then 4 `rx_done` pulses with data 0x41, 0x42, 0x43, 0x44 and no errors -> `full`=1. 4 `rd_en` pops return 0x41..0x44 in order, then `empty`=1 and `rd_data`=0.
- FIFO full, 5th `rx_done` with 0x55 -> frame dropped and `overrun`=1. `ovr_clr` -> 0. Repeat with `ovr_clr` and the drop in the same cycle -> `overrun` stays 1.
- FIFO full, `rx_done` 0x66 together with `rd_en` -> count stays 4, `overrun`=0, and 0x66 is the last entry read.
- `rx_busy`=1, `cfg_wr` with par=2, d_num=0, s_num=1 -> `par`=0, `d_num`=1, `s_num`=0 held and `cfg_pending`=1. `rx_busy` falls at edge M -> `par`=2, `d_num`=0, `s_num`=1 after M+1.
- `d_num`=0 applied, `rx_done` with 0xC1 and `rx_err`=3'b110 -> `rd_data`=0x41, `rd_err`=2'b11.
- Reset asserted with 3 entries stored and `cfg_pending`=1 -> `empty`=1, 8N1 restored, `cfg_pending`=0, `overrun`=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver companion: owns the applied frame format and changes it only between frames,
// and buffers completed frames (data + parity/frame flags) in a FWFT FIFO with a sticky overrun.
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk_rx,
    input  logic          reset,
    input  logic          cfg_wr,
    input  logic [1:0]    cfg_par,
    input  logic          cfg_d_num,
    input  logic          cfg_s_num,
    output logic [1:0]    par,
    output logic          d_num,
    output logic          s_num,
    output logic          cfg_pending,
    input  logic          rx_busy,
    input  logic          rx_done,
    input  logic [DW-1:0] rx_dout,
    input  logic [2:0]    rx_err,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    rd_err,
    output logic          empty,
    output logic          full,
    output logic          overrun,
    input  logic          ovr_clr
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          EW       = DW + 2;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_APPLY     = 2'd2
    } cfg_state_t;

    cfg_state_t    state_r, state_next_s;
    logic          shadow_ld_s, apply_s;
    logic [1:0]    sh_par_r, par_r;
    logic          sh_d_num_r, sh_s_num_r, d_num_r, s_num_r, pending_r;

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_next_s;
    logic          empty_r, full_r, overrun_r;
    logic          push_s, pop_s;
    logic [EW-1:0] wr_entry_s, head_s;

    // The receiver's own overrun bit is not used; overrun is tracked against this FIFO.
    logic          unused_rx_ovr_s;
    assign unused_rx_ovr_s = rx_err[0];

    // Config FSM next-state: shadow latch decisions and apply strobe.
    always_comb begin
        state_next_s = state_r;
        shadow_ld_s  = 1'b0;
        apply_s      = 1'b0;
        case (state_r)
            ST_RUN, ST_APPLY: begin
                apply_s = (state_r == ST_APPLY);
                if (cfg_wr) begin
                    shadow_ld_s  = 1'b1;
                    state_next_s = rx_busy ? ST_WAIT_IDLE : ST_APPLY;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_WAIT_IDLE: begin
                shadow_ld_s = cfg_wr;
                if (rx_busy) begin
                    state_next_s = ST_WAIT_IDLE;
                end else begin
                    state_next_s = ST_APPLY;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Config state, shadow and applied format registers.
    always_ff @(posedge clk_rx) begin
        if (reset) begin
            state_r    <= ST_RUN;
            sh_par_r   <= 2'd0;
            sh_d_num_r <= 1'b1;
            sh_s_num_r <= 1'b0;
            par_r      <= 2'd0;
            d_num_r    <= 1'b1;
            s_num_r    <= 1'b0;
            pending_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= (state_next_s != ST_RUN);
            if (apply_s) begin
                par_r   <= sh_par_r;
                d_num_r <= sh_d_num_r;
                s_num_r <= sh_s_num_r;
            end
            if (shadow_ld_s) begin
                sh_par_r   <= cfg_par;
                sh_d_num_r <= cfg_d_num;
                sh_s_num_r <= cfg_s_num;
            end
        end
    end

    // FIFO control: a push into a full FIFO is allowed only when a pop frees the head slot.
    always_comb begin
        push_s     = rx_done && (!full_r || rd_en);
        pop_s      = rd_en && !empty_r;
        wr_entry_s = {rx_err[2:1], rx_dout};
        wr_entry_s[DW-1] = rx_dout[DW-1] & d_num_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
        head_s = mem_r[rd_ptr_r];
        if (empty_r) begin
            rd_data = {DW{1'b0}};
            rd_err  = 2'b00;
        end else begin
            rd_data = head_s[DW-1:0];
            rd_err  = head_s[EW-1:DW];
        end
    end

    // FIFO storage; contents are never observed while empty, so no reset is needed.
    always_ff @(posedge clk_rx) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // FIFO pointers, occupancy flags and sticky overrun (set beats clear).
    always_ff @(posedge clk_rx) begin
        if (reset) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW+1){1'b0}};
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == {(AW+1){1'b0}});
            full_r  <= (count_next_s == FULL_CNT);
            if (rx_done && !push_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign par         = par_r;
    assign d_num       = d_num_r;
    assign s_num       = s_num_r;
    assign cfg_pending = pending_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed scenarios followed by randomized traffic,
// checked against a behavioural model of the FIFO contents and format-change rules.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk_rx = 1'b0;
    logic          reset = 1'b0, cfg_wr = 1'b0, cfg_d_num = 1'b0, cfg_s_num = 1'b0;
    logic [1:0]    cfg_par = 2'd0;
    logic [1:0]    par;
    logic          d_num, s_num, cfg_pending;
    logic          rx_busy = 1'b0, rx_done = 1'b0, rd_en = 1'b0, ovr_clr = 1'b0;
    logic [DW-1:0] rx_dout = 8'h00;
    logic [2:0]    rx_err = 3'b000;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_err;
    logic          empty, full, overrun;

    always #5 clk_rx = ~clk_rx;

    uart_rx_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk_rx(clk_rx), .reset(reset), .cfg_wr(cfg_wr), .cfg_par(cfg_par),
        .cfg_d_num(cfg_d_num), .cfg_s_num(cfg_s_num), .par(par), .d_num(d_num),
        .s_num(s_num), .cfg_pending(cfg_pending), .rx_busy(rx_busy), .rx_done(rx_done),
        .rx_dout(rx_dout), .rx_err(rx_err), .rd_en(rd_en), .rd_data(rd_data),
        .rd_err(rd_err), .empty(empty), .full(full), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected FIFO contents, occupancy, overrun and format state.
    logic [9:0] exp_q[$];
    int         mcount = 0;
    logic       m_ovr = 1'b0;
    logic [1:0] m_par = 2'd0, sh_par = 2'd0;
    logic       m_dnum = 1'b1, m_snum = 1'b0, sh_dnum = 1'b1, sh_snum = 1'b0;
    logic       have_req = 1'b0, apply_next = 1'b0;
    bit         started = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Predicts the state after the coming clock edge from the inputs now applied.
    function automatic void model_update();
        bit         do_pop, do_push;
        logic [7:0] d;
        if (reset) begin
            exp_q.delete();
            mcount = 0; m_ovr = 1'b0;
            m_par = 2'd0; m_dnum = 1'b1; m_snum = 1'b0;
            have_req = 1'b0; apply_next = 1'b0;
        end else begin
            do_pop  = rd_en && (mcount > 0);
            do_push = rx_done && ((mcount < DEPTH) || rd_en);
            if (do_push) begin
                d = rx_dout;
                if (!m_dnum) d = d & 8'h7F;
                exp_q.push_back({rx_err[2:1], d});
            end
            mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            if (rx_done && !do_push) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            if (apply_next) begin
                m_par = sh_par; m_dnum = sh_dnum; m_snum = sh_snum;
                apply_next = 1'b0;
            end
            if (cfg_wr) begin
                sh_par = cfg_par; sh_dnum = cfg_d_num; sh_snum = cfg_s_num;
                have_req = 1'b1;
            end
            if (have_req && !rx_busy) begin
                apply_next = 1'b1;
                have_req   = 1'b0;
            end
        end
    endfunction

    // Scoreboard monitor: every DUT pop must deliver the oldest expected entry.
    always @(negedge clk_rx) begin
        logic [9:0] e;
        if (rd_en && !empty && !reset) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no entry at %0t", {rd_err, rd_data}, $time);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", {22'd0, rd_err, rd_data}, {22'd0, e});
            end
        end
    end

    // State monitor: registered outputs and FIFO head just after each edge.
    always @(posedge clk_rx) begin
        #1;
        if (started) begin
            check("empty", {31'd0, empty}, {31'd0, mcount == 0});
            check("full", {31'd0, full}, {31'd0, mcount == DEPTH});
            check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            check("cfg_pending", {31'd0, cfg_pending}, {31'd0, have_req || apply_next});
            check("format", {28'd0, par, d_num, s_num}, {28'd0, m_par, m_dnum, m_snum});
            if (mcount == 0) check("head_when_empty", {22'd0, rd_err, rd_data}, 32'd0);
            else             check("head", {22'd0, rd_err, rd_data}, {22'd0, exp_q[0]});
        end
    end

    task automatic tick();
        model_update();
        started = 1'b1;
        @(posedge clk_rx);
        #2;
        rx_done = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0; cfg_wr = 1'b0; reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] e);
        rx_done = 1'b1; rx_dout = d; rx_err = e;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
    endtask

    task automatic cfg(input logic [1:0] p, input logic dn, input logic sn);
        cfg_wr = 1'b1; cfg_par = p; cfg_d_num = dn; cfg_s_num = sn;
    endtask

    initial begin
        @(posedge clk_rx);
        #2;
        reset = 1'b1; tick();

        // In-order fill and drain.
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i), 3'b000);
        repeat (4) pop();
        tick();

        // Drop on full sets overrun; clear; then clear coinciding with a new drop.
        for (int i = 0; i < 4; i++) push(8'($urandom), 3'($urandom));
        push(8'h55, 3'b000);
        ovr_clr = 1'b1; tick();
        rx_done = 1'b1; rx_dout = 8'h57; ovr_clr = 1'b1; tick();
        ovr_clr = 1'b1; tick();

        // Simultaneous push and pop while full.
        rx_done = 1'b1; rx_dout = 8'h66; rx_err = 3'b000; rd_en = 1'b1; tick();
        repeat (4) pop();

        // Simultaneous push and pop while empty.
        rx_done = 1'b1; rx_dout = 8'h3C; rd_en = 1'b1; tick();
        pop();

        // Format change deferred while the receiver is mid-frame.
        rx_busy = 1'b1; cfg(2'd2, 1'b0, 1'b1); tick();
        repeat (3) tick();
        rx_busy = 1'b0; tick();
        repeat (2) tick();

        // 7-bit mode masks bit 7; parity/frame flags are stored.
        push(8'hC1, 3'b110);
        pop();

        // Idle config write: two-edge latency back to 8N1.
        cfg(2'd0, 1'b1, 1'b0); tick();
        repeat (2) tick();

        // Reset with stored entries and a pending change.
        for (int i = 0; i < 3; i++) push(8'($urandom), 3'b000);
        rx_busy = 1'b1; cfg(2'd1, 1'b0, 1'b1); tick();
        reset = 1'b1; tick();
        rx_busy = 1'b0; tick();

        // Randomized traffic: a fill-heavy phase then a drain-heavy phase.
        for (int i = 0; i < 3000; i++) begin
            rx_done = ($urandom_range(2, 0) == 0);
            rx_dout = 8'($urandom);
            rx_err  = 3'($urandom);
            rd_en   = (i < 1500) ? ($urandom_range(4, 0) == 0) : ($urandom_range(1, 0) == 0);
            ovr_clr = ($urandom_range(15, 0) == 0);
            if ($urandom_range(3, 0) == 0) rx_busy = ~rx_busy;
            if ($urandom_range(19, 0) == 0) cfg(2'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        rx_busy = 1'b0;
        repeat (DEPTH + 1) pop();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
